// File: rtl/uart_share_ctrl_pkg.sv
// Shared definitions for the console UART sharing controller:
// lock FSM encoding, owner index width and the default lock timeout.
package uart_share_ctrl_pkg;

    // Lock FSM: either nobody holds the UART TX side, or one requester does.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } share_state_e;

    // Owner index width covers up to MAX_REQ requesters.
    localparam int OWNER_W              = 2;
    localparam int MAX_REQ              = 4;
    localparam int DEFAULT_LOCK_TIMEOUT = 65535;

    // Round-robin successor of a granted index, wrapping modulo nreq.
    function automatic logic [OWNER_W-1:0] rr_next(input logic [OWNER_W-1:0] idx,
                                                  input int                 nreq);
        logic [OWNER_W-1:0] nxt;
        if (int'(idx) >= (nreq - 1)) begin
            nxt = {OWNER_W{1'b0}};
        end else begin
            nxt = idx + OWNER_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/uart_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request bit
// at or after the pointer, wrapping modulo N. Usable by any shared-peripheral
// controller with up to MAX_REQ requesters.
module uart_share_ctrl_rr_arbiter
    import uart_share_ctrl_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]       req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [OWNER_W-1:0] grant,
    output logic               valid
);

    logic [MAX_REQ-1:0] req_ext_s;
    logic [OWNER_W:0]   sum_s;
    logic [OWNER_W-1:0] idx_s;
    logic [OWNER_W-1:0] grant_s;
    logic               valid_s;
    logic               hit_s;

    // Scan requesters starting at the pointer and keep the first hit.
    always_comb begin
        req_ext_s          = {MAX_REQ{1'b0}};
        req_ext_s[N-1:0]   = req;
        grant_s            = {OWNER_W{1'b0}};
        valid_s            = 1'b0;
        sum_s              = {(OWNER_W+1){1'b0}};
        idx_s              = {OWNER_W{1'b0}};
        hit_s              = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum_s   = {1'b0, ptr} + (OWNER_W+1)'(k);
            sum_s   = (sum_s >= (OWNER_W+1)'(N)) ? (sum_s - (OWNER_W+1)'(N)) : sum_s;
            idx_s   = sum_s[OWNER_W-1:0];
            hit_s   = req_ext_s[idx_s] && !valid_s;
            grant_s = hit_s ? idx_s : grant_s;
            valid_s = valid_s || hit_s;
        end
    end

    assign grant = grant_s;
    assign valid = valid_s;

endmodule

// File: rtl/uart_share_ctrl.sv
// Shares one console UART register port between NREQ byte-stream requesters.
// TX: round-robin arbitration with a lock held for a whole message (until the
// byte flagged tx_last has been written, or the owner goes quiet for
// LOCK_TIMEOUT cycles). One byte is buffered in a hold register that drives
// the UART write strobe. RX: bytes are pulled from the UART one at a time and
// routed to the owner sampled at capture.
module uart_share_ctrl
    import uart_share_ctrl_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT,
    parameter int TW           = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      tx_valid,
    input  logic [8*NREQ-1:0]    tx_data,
    input  logic [NREQ-1:0]      tx_last,
    output logic [NREQ-1:0]      tx_ready,
    output logic [NREQ-1:0]      rx_valid,
    output logic [7:0]           rx_data,
    input  logic [NREQ-1:0]      rx_ready,
    output logic                 uart_we,
    output logic [7:0]           uart_di,
    input  logic                 uart_wait,
    output logic                 uart_re,
    input  logic [7:0]           uart_do,
    input  logic                 uart_rxv,
    output logic [1:0]           owner,
    output logic                 locked
);

    // Lock FSM
    share_state_e        state_r, state_n;
    logic [OWNER_W-1:0]  owner_r, owner_n;
    logic [OWNER_W-1:0]  rr_ptr_r, rr_ptr_n;
    logic                locked_r, locked_n;
    logic [OWNER_W-1:0]  arb_grant_s;
    logic                arb_valid_s;

    // TX hold buffer and idle timeout
    logic [7:0]          hold_r;
    logic                hold_last_r;
    logic                hold_full_r;
    logic [TW-1:0]       tmo_cnt_r;

    // Owner-selected views of the requester buses
    logic [MAX_REQ-1:0]   tx_valid_ext_s;
    logic [MAX_REQ-1:0]   tx_last_ext_s;
    logic [MAX_REQ-1:0]   tx_ready_ext_s;
    logic [8*MAX_REQ-1:0] tx_data_ext_s;
    logic                 own_valid_s;
    logic                 own_last_s;
    logic [7:0]           own_data_s;

    logic                 accept_s;
    logic                 drain_s;
    logic                 timeout_s;

    // RX path
    logic                 uart_re_r;
    logic [7:0]           rx_data_r;
    logic [NREQ-1:0]      rx_valid_r;
    logic [MAX_REQ-1:0]   rx_sel_ext_s;
    logic                 rx_pending_s;
    logic                 rx_start_s;
    logic                 rx_done_s;

    uart_share_ctrl_rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req   (tx_valid),
        .ptr   (rr_ptr_r),
        .grant (arb_grant_s),
        .valid (arb_valid_s)
    );

    // Widen requester buses so they can be indexed by the owner register.
    always_comb begin
        tx_valid_ext_s                  = {MAX_REQ{1'b0}};
        tx_last_ext_s                   = {MAX_REQ{1'b0}};
        tx_data_ext_s                   = {(8*MAX_REQ){1'b0}};
        tx_valid_ext_s[NREQ-1:0]        = tx_valid;
        tx_last_ext_s[NREQ-1:0]         = tx_last;
        tx_data_ext_s[8*NREQ-1:0]       = tx_data;
        own_valid_s                     = tx_valid_ext_s[owner_r];
        own_last_s                      = tx_last_ext_s[owner_r];
        own_data_s                      = tx_data_ext_s[{owner_r, 3'b000} +: 8];
    end

    // Only the lock owner sees ready, and only while the hold buffer is empty.
    always_comb begin
        tx_ready_ext_s          = {MAX_REQ{1'b0}};
        tx_ready_ext_s[owner_r] = (state_r == ST_LOCK) && !hold_full_r;
        tx_ready                = tx_ready_ext_s[NREQ-1:0];
    end

    assign accept_s  = (state_r == ST_LOCK) && !hold_full_r && own_valid_s;
    assign drain_s   = hold_full_r && !uart_wait;
    assign timeout_s = (state_r == ST_LOCK) && (tmo_cnt_r == TW'(LOCK_TIMEOUT));

    // Next-state logic: grant from IDLE, release on last byte drained or timeout.
    always_comb begin
        state_n  = state_r;
        owner_n  = owner_r;
        rr_ptr_n = rr_ptr_r;
        locked_n = locked_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    state_n  = ST_LOCK;
                    owner_n  = arb_grant_s;
                    rr_ptr_n = rr_next(arb_grant_s, NREQ);
                    locked_n = 1'b1;
                end else begin
                    state_n  = ST_IDLE;
                    locked_n = 1'b0;
                end
            end
            ST_LOCK: begin
                if (drain_s && hold_last_r) begin
                    state_n  = ST_IDLE;
                    locked_n = 1'b0;
                end else if (timeout_s && !accept_s) begin
                    // An owner resuming exactly at expiry keeps its lock so
                    // the accepted byte is never orphaned.
                    state_n  = ST_IDLE;
                    locked_n = 1'b0;
                end else begin
                    state_n  = ST_LOCK;
                    locked_n = 1'b1;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                locked_n = 1'b0;
            end
        endcase
    end

    // Lock FSM state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= ST_IDLE;
            owner_r  <= {OWNER_W{1'b0}};
            rr_ptr_r <= {OWNER_W{1'b0}};
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_n;
            owner_r  <= owner_n;
            rr_ptr_r <= rr_ptr_n;
            locked_r <= locked_n;
        end
    end

    // Hold buffer: loaded on accept, emptied when the UART takes the write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_r      <= 8'h00;
            hold_last_r <= 1'b0;
            hold_full_r <= 1'b0;
        end else if (accept_s) begin
            hold_r      <= own_data_s;
            hold_last_r <= own_last_s;
            hold_full_r <= 1'b1;
        end else if (drain_s) begin
            hold_full_r <= 1'b0;
        end else begin
            hold_full_r <= hold_full_r;
        end
    end

    // Idle counter: runs while the owner offers nothing and the buffer is empty;
    // it stops at LOCK_TIMEOUT instead of wrapping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (state_r != ST_LOCK) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (accept_s) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else if (!hold_full_r && !own_valid_s && !timeout_s) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    assign uart_we = hold_full_r;
    assign uart_di = hold_r;

    assign rx_pending_s = |rx_valid_r;
    assign rx_start_s   = uart_rxv && !rx_pending_s && !uart_re_r;
    assign rx_done_s    = |(rx_valid_r & rx_ready);

    // One-hot routing vector for the current owner.
    always_comb begin
        rx_sel_ext_s          = {MAX_REQ{1'b0}};
        rx_sel_ext_s[owner_r] = 1'b1;
    end

    // Single-cycle UART read strobe, never back-to-back, never with a byte pending.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            uart_re_r <= 1'b0;
        end else begin
            uart_re_r <= rx_start_s;
        end
    end

    // Capture the read byte and route it to the owner at capture time.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_data_r  <= 8'h00;
            rx_valid_r <= {NREQ{1'b0}};
        end else if (uart_re_r) begin
            rx_data_r  <= uart_do;
            rx_valid_r <= rx_sel_ext_s[NREQ-1:0];
        end else if (rx_done_s) begin
            rx_valid_r <= {NREQ{1'b0}};
        end else begin
            rx_valid_r <= rx_valid_r;
        end
    end

    assign uart_re  = uart_re_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign owner    = owner_r;
    assign locked   = locked_r;

endmodule

// File: tb/tb_uart_share_ctrl.sv
// Directed bench for uart_share_ctrl: a queue-fed requester driver, a UART
// write monitor checking against an expected-write scoreboard, and a linear
// sequence of test steps in one initial block.
module tb_uart_share_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  tx_valid;
    logic [15:0] tx_data;
    logic [1:0]  tx_last;
    logic [1:0]  tx_ready;
    logic [1:0]  rx_valid;
    logic [7:0]  rx_data;
    logic [1:0]  rx_ready;
    logic        uart_we;
    logic [7:0]  uart_di;
    logic        uart_wait;
    logic        uart_re;
    logic [7:0]  uart_do;
    logic        uart_rxv;
    logic [1:0]  owner;
    logic        locked;

    int chk_cnt = 0;
    int err_cnt = 0;

    logic [8:0] txq0[$];
    logic [8:0] txq1[$];
    logic [9:0] exp_q[$];

    uart_share_ctrl #(
        .NREQ         (2),
        .LOCK_TIMEOUT (8),
        .TW           (16)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .uart_we   (uart_we),
        .uart_di   (uart_di),
        .uart_wait (uart_wait),
        .uart_re   (uart_re),
        .uart_do   (uart_do),
        .uart_rxv  (uart_rxv),
        .owner     (owner),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input int req, input logic [7:0] d, input logic last);
        if (req == 0) txq0.push_back({last, d});
        else          txq1.push_back({last, d});
    endtask

    task automatic expect_wr(input logic [1:0] own, input logic [7:0] d);
        exp_q.push_back({own, d});
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        resetn = 1'b0;
        txq0.delete();
        txq1.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        resetn = 1'b1;
    endtask

    task automatic wait_writes(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_we(input string tag, input int budget);
        int n = 0;
        while (uart_we !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(uart_we), 32'd1);
    endtask

    task automatic wait_locked(input string tag, input int budget);
        int n = 0;
        while (locked !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(locked), 32'd1);
    endtask

    // Requester driver: presents the head of each queue, pops on handshake.
    initial begin
        logic [1:0] hs;
        tx_valid = 2'b00;
        tx_data  = 16'h0000;
        tx_last  = 2'b00;
        forever begin
            @(negedge clk);
            hs = tx_valid & tx_ready;
            @(posedge clk); #1;
            if (hs[0] && txq0.size() > 0) void'(txq0.pop_front());
            if (hs[1] && txq1.size() > 0) void'(txq1.pop_front());
            tx_valid = 2'b00;
            tx_last  = 2'b00;
            tx_data  = 16'h0000;
            if (txq0.size() > 0) begin
                tx_valid[0]  = 1'b1;
                tx_last[0]   = txq0[0][8];
                tx_data[7:0] = txq0[0][7:0];
            end
            if (txq1.size() > 0) begin
                tx_valid[1]   = 1'b1;
                tx_last[1]    = txq1[0][8];
                tx_data[15:8] = txq1[0][7:0];
            end
        end
    end

    // UART write monitor: every completed write must match the scoreboard head.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && uart_we === 1'b1 && uart_wait === 1'b0) begin
                check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_data", 32'(uart_di), 32'(e[7:0]));
                    check("wr_owner", 32'(owner), 32'(e[9:8]));
                end
            end
        end
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int re_cnt;
        resetn    = 1'b1;
        uart_wait = 1'b0;
        uart_rxv  = 1'b0;
        uart_do   = 8'h00;
        rx_ready  = 2'b00;
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_owner",    32'(owner),    32'd0);
        check("rst_locked",   32'(locked),   32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        check("rst_uart_we",  32'(uart_we),  32'd0);
        check("rst_uart_re",  32'(uart_re),  32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data",  32'(rx_data),  32'd0);
        @(posedge clk); #2;
        resetn = 1'b1;

        // 1: requester 0 sends "Hi"
        push_tx(0, 8'h48, 1'b0);
        push_tx(0, 8'h69, 1'b1);
        expect_wr(2'd0, 8'h48);
        expect_wr(2'd0, 8'h69);
        wait_locked("t1_locked", 20);
        check("t1_ready", 32'(tx_ready), 32'd1);
        check("t1_owner", 32'(owner),    32'd0);
        wait_writes("t1_done", 50);
        check("t1_unlocked", 32'(locked), 32'd0);
        check("t1_owner_kept", 32'(owner), 32'd0);

        // 2: both requesters valid from reset, round-robin with message lock
        do_reset();
        push_tx(0, 8'hA0, 1'b0);
        push_tx(0, 8'hA1, 1'b0);
        push_tx(0, 8'hA2, 1'b1);
        push_tx(0, 8'hC0, 1'b1);
        push_tx(1, 8'hB0, 1'b0);
        push_tx(1, 8'hB1, 1'b0);
        push_tx(1, 8'hB2, 1'b1);
        expect_wr(2'd0, 8'hA0);
        expect_wr(2'd0, 8'hA1);
        expect_wr(2'd0, 8'hA2);
        expect_wr(2'd1, 8'hB0);
        expect_wr(2'd1, 8'hB1);
        expect_wr(2'd1, 8'hB2);
        expect_wr(2'd0, 8'hC0);
        wait_writes("t2_done", 200);
        check("t2_unlocked", 32'(locked), 32'd0);

        // 3: UART busy for 10 cycles during a write
        do_reset();
        @(posedge clk); #2;
        uart_wait = 1'b1;
        push_tx(0, 8'h5A, 1'b1);
        expect_wr(2'd0, 8'h5A);
        wait_we("t3_we_rise", 20);
        for (int i = 0; i < 10; i++) begin
            check("t3_we_hold",    32'(uart_we),  32'd1);
            check("t3_di_hold",    32'(uart_di),  32'h5A);
            check("t3_ready_low",  32'(tx_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #2;
        uart_wait = 1'b0;
        @(negedge clk);
        check("t3_we_final", 32'(uart_we), 32'd1);
        @(negedge clk);
        check("t3_hold_clear", 32'(uart_we), 32'd0);
        check("t3_unlocked",   32'(locked),  32'd0);
        wait_writes("t3_done", 10);

        // 4: owner stalls mid-message, lock times out after 8 idle cycles
        do_reset();
        push_tx(0, 8'h11, 1'b0);
        push_tx(1, 8'h22, 1'b0);
        expect_wr(2'd0, 8'h11);
        expect_wr(2'd1, 8'h22);
        wait_we("t4_first_write", 20);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check("t4_lock_held", 32'(locked), 32'd1);
        end
        @(negedge clk);
        check("t4_timeout_release", 32'(locked), 32'd0);
        check("t4_owner_kept",      32'(owner),  32'd0);
        @(negedge clk);
        check("t4_regrant_locked", 32'(locked),   32'd1);
        check("t4_regrant_owner",  32'(owner),    32'd1);
        check("t4_regrant_ready",  32'(tx_ready), 32'd2);
        wait_writes("t4_done", 20);

        // 5: received byte routed to owner 1
        check("t5_owner", 32'(owner), 32'd1);
        @(posedge clk); #2;
        rx_ready = 2'b01;
        uart_do  = 8'h41;
        uart_rxv = 1'b1;
        re_cnt   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uart_re === 1'b1) re_cnt++;
        end
        check("t5_re_pulses", 32'(re_cnt),   32'd1);
        check("t5_rx_valid",  32'(rx_valid), 32'd2);
        check("t5_rx_data",   32'(rx_data),  32'h41);
        @(posedge clk); #2;
        rx_ready = 2'b10;
        uart_rxv = 1'b0;
        @(negedge clk);
        check("t5_rx_hs_cycle", 32'(rx_valid), 32'd2);
        @(negedge clk);
        check("t5_rx_cleared", 32'(rx_valid), 32'd0);
        @(posedge clk); #2;
        rx_ready = 2'b00;

        // 6: reset mid-message with a write stalled in the UART
        @(posedge clk); #2;
        uart_wait = 1'b1;
        push_tx(0, 8'h33, 1'b0);
        wait_we("t6_stalled", 40);
        @(posedge clk); #2;
        resetn = 1'b0;
        txq0.delete();
        txq1.delete();
        exp_q.delete();
        #1;
        check("t6_we_low",     32'(uart_we),  32'd0);
        check("t6_locked_low", 32'(locked),   32'd0);
        check("t6_ready_low",  32'(tx_ready), 32'd0);
        uart_wait = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        resetn = 1'b1;
        push_tx(1, 8'h01, 1'b1);
        push_tx(0, 8'h02, 1'b1);
        expect_wr(2'd0, 8'h02);
        expect_wr(2'd1, 8'h01);
        wait_writes("t6_done", 60);
        check("t6_unlocked", 32'(locked), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
